stream_demux4: RTL and testbench
================================

// Module: stream_demux4
// PURPOSE
//   1-to-4 stream demultiplexer with valid/ready handshakes; the write-side counterpart of mux4to1.
//   Routes each packet from a single input stream to one of four output channels chosen by in_sel.
//   Holds the route for the whole packet and buffers one beat (registered outputs).
//   Counts completed packets per channel and flags select changes inside a packet.
// PARAMETERS
//   W    8  data width in bits
//   CW   8  width of each per-channel packet counter (wraps at 2**CW)
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous, active-low reset
//   in_valid   in   1     input beat valid
//   in_ready   out  1     input beat accepted when in_valid && in_ready
//   in_data    in   W     input beat data
//   in_last    in   1     final beat of the packet
//   in_sel     in   2     destination channel; sampled on the first beat of a packet only
//   out_valid  out  4     one-hot (or zero) per-channel valid
//   out_ready  in   4     per-channel ready
//   out_data   out  W     shared output data, meaningful for the channel with out_valid set
//   out_last   out  1     shared last flag
//   err_sel    out  1     sticky: in_sel differed from the locked route on an accepted mid-packet beat
//   err_clr    in   1     synchronous clear of err_sel
//   pkt_cnt    out  4*CW  packets completed per channel; channel k at [k*CW +: CW]
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - out_valid=0, out_data=0, out_last=0, err_sel=0, pkt_cnt=0, FSM=IDLE, buffer empty.
//     - in_ready=0 while rst_n=0.
//   Buffer: one entry {data, last, sel}; buf_valid is the OR of out_valid.
//     - in_ready = !buf_valid || out_ready[buf_sel]. Combinational from out_ready; no path from in_valid.
//   Accept: on in_valid && in_ready, the beat is written into the buffer at the next edge.
//     - out_valid[dest] is set from that edge, giving latency 1.
//     - Drain and refill in the same cycle give 1 beat/cycle throughput.
//   Hold: while out_valid[k] && !out_ready[k], out_valid, out_data and out_last stay stable.
//   Drain: on out_valid[k] && out_ready[k] with no new accept, out_valid clears at the next edge.
//     - out_data and out_last keep their last values.
//   FSM:
//     - IDLE: dest = in_sel.
//       Accept with in_last=0 -> LOCKED, with locked_sel = in_sel.
//       Accept with in_last=1 -> stay IDLE (single-beat packet).
//     - LOCKED: dest = locked_sel; in_sel is ignored for routing.
//       Accept with in_last=1 -> IDLE.
//   err_sel:
//     - Set on any accepted LOCKED beat where in_sel != locked_sel.
//     - err_clr=1 clears it; if set and clear happen in the same cycle, set wins.
//   pkt_cnt[k]:
//     - Increments when a beat with last=1 completes its handshake on channel k (out_valid[k] && out_ready[k]).
//     - Wraps from 2**CW-1 to 0.
//   out_ready bits for channels not currently valid are don't-care.
//   Reset mid-packet: the buffered beat is discarded, the FSM returns to IDLE, and the route is forgotten.
//   in_sel must not be X/Z on an accepted IDLE beat (checked by assertion).
// TESTING
//   1. Single beat: in_sel=2, data=0xA5, last=1, out_ready=4'b1111.
//      -> Next cycle out_valid=4'b0100, out_data=0xA5, out_last=1, pkt_cnt[2]=1 one cycle later.
//   2. 3-beat packet, in_sel=1 then 3 then 0 on beats 2 and 3.
//      -> All beats on channel 1, err_sel=1 after beat 2.
//      -> err_clr pulse -> err_sel=0.
//   3. Backpressure: channel 0 packet, out_ready[0]=0 for 5 cycles.
//      -> in_ready=0 after first accept; out_data held stable; no beat lost or duplicated once ready returns.
//   4. Streaming: 16 back-to-back beats, out_ready=1.
//      -> in_ready stays 1, one beat per cycle, order preserved, latency exactly 1.
//   5. Counter wrap (CW=2): 5 single-beat packets to channel 3.
//      -> pkt_cnt[3] sequence 1,2,3,0,1.
//   6. rst_n low mid-packet with a beat buffered.
//      -> out_valid=0 immediately; after release, in_sel=2 first beat routes to channel 2.

Source files
------------

// File: rtl/stream_demux4_if.sv
// Handshake bundle for stream_demux4.
//   in_valid/in_ready/in_data/in_last/in_sel : single upstream stream
//   out_valid/out_ready (per channel), out_data/out_last (shared) : four downstream channels
// slave  : seen from the demux
// master : seen from the environment driving the demux
interface stream_demux4_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_demux4.sv
// 1-to-4 stream demultiplexer with a one-beat output buffer.
// The first beat of a packet picks the channel from in_sel; the route is held
// until the last beat. Completed packets are counted per channel, and a sticky
// flag records select changes seen inside a packet.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : handshake bundle (stream_demux4_if.slave)
//   err_sel    : sticky mid-packet select-change flag
//   err_clr    : synchronous clear of err_sel (a simultaneous set wins)
//   pkt_cnt    : per-channel completed-packet counters, channel k at [k*CW +: CW]
//
// state  | meaning
// IDLE   | next accepted beat starts a packet; route taken from in_sel
// LOCKED | inside a multi-beat packet; route taken from locked_sel
module stream_demux4 #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux4_if.slave  bus,
  output logic            err_sel,
  input  logic            err_clr,
  output logic [4*CW-1:0] pkt_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t       state;
  logic [1:0]   locked_sel;
  logic [1:0]   buf_sel;
  logic [3:0]   valid_q;
  logic [W-1:0] data_q;
  logic         last_q;

  logic       buf_valid;
  logic       accept;
  logic [1:0] dest;

  assign buf_valid = |valid_q;
  // Ready depends only on the buffer and downstream ready, never on in_valid.
  assign bus.in_ready = rst_n && (!buf_valid || bus.out_ready[buf_sel]);
  assign accept = bus.in_valid && bus.in_ready;
  assign dest   = (state == IDLE) ? bus.in_sel : locked_sel;

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      locked_sel <= 2'd0;
      buf_sel    <= 2'd0;
      valid_q    <= 4'd0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_sel    <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      // A new accept overwrites the buffer even while it drains, so the
      // buffer sustains one beat per cycle.
      if (accept) begin
        valid_q <= 4'b0001 << dest;
        data_q  <= bus.in_data;
        last_q  <= bus.in_last;
        buf_sel <= dest;
      end else if (buf_valid && bus.out_ready[buf_sel]) begin
        valid_q <= 4'd0;
      end

      for (int k = 0; k < 4; k++) begin
        if (valid_q[k] && bus.out_ready[k] && last_q)
          pkt_cnt[k*CW +: CW] <= pkt_cnt[k*CW +: CW] + CW'(1);
      end

      case (state)
        IDLE: begin
          if (accept && !bus.in_last) begin
            state      <= LOCKED;
            locked_sel <= bus.in_sel;
          end
        end
        LOCKED: begin
          if (accept && bus.in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept && state == LOCKED && bus.in_sel != locked_sel)
        err_sel <= 1'b1;
      else if (err_clr)
        err_sel <= 1'b0;
    end
  end

  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.in_valid && bus.in_ready && state == IDLE) |-> !$isunknown(bus.in_sel));

endmodule

// File: tb/tb_stream_demux4.sv
module tb_stream_demux4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            err_sel;
  logic            err_clr = 1'b0;
  logic [4*CW-1:0] pkt_cnt;

  stream_demux4_if #(.W(W)) bus ();

  stream_demux4 #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_sel (err_sel),
    .err_clr (err_clr),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t sb[$];
  int    exp_cnt [4];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one beat, waits (bounded) for acceptance and queues the expected output.
  task automatic send(input logic [1:0] sel, input logic [W-1:0] data, input logic last,
                      input int exp_ch, output int waits);
    beat_t b;
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.in_last  = last;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        b.ch = exp_ch; b.data = data; b.last = last;
        sb.push_back(b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        break;
      end
      waits++;
      if (waits > 50) begin
        errors++;
        $display("FAIL send_timeout: beat 0x%0h never accepted", data);
        bus.in_valid = 1'b0;
        break;
      end
    end
  endtask

  // Monitor: compares every completed output handshake with the scoreboard
  // and tracks the expected per-channel packet counts.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      sb.delete();
      for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        chk($sformatf("pkt_cnt%0d", k), 32'(pkt_cnt[k*CW +: CW]), 32'(exp_cnt[k]));
      chk("onehot", 32'($onehot0(bus.out_valid)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra: ch %0d data 0x%0h with nothing expected", k, bus.out_data);
          end else begin
            e = sb.pop_front();
            chk("sb_ch", 32'(k), 32'(e.ch));
            chk("sb_data", 32'(bus.out_data), 32'(e.data));
            chk("sb_last", 32'(bus.out_last), 32'(e.last));
          end
          if (bus.out_last) exp_cnt[k] = (exp_cnt[k] + 1) % (1 << CW);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic [1:0] wrap_seq [5];
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_sel    = 2'd0;
    bus.out_ready = 4'b1111;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err_sel", 32'(err_sel), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: single beat to channel 2
    send(2'd2, 8'hA5, 1'b1, 2, w);
    chk("t1_out_valid", 32'(bus.out_valid), 32'h4);
    chk("t1_out_data", 32'(bus.out_data), 32'hA5);
    chk("t1_out_last", 32'(bus.out_last), 32'd1);
    @(posedge clk); #1;
    chk("t1_pkt_cnt2", 32'(pkt_cnt[2*CW +: CW]), 32'd1);
    chk("t1_drained", 32'(bus.out_valid), 32'd0);
    chk("t1_data_kept", 32'(bus.out_data), 32'hA5);

    // 2: 3-beat packet on channel 1 with select changes mid-packet
    send(2'd1, 8'h10, 1'b0, 1, w);
    chk("t2_err_beat1", 32'(err_sel), 32'd0);
    send(2'd3, 8'h11, 1'b0, 1, w);
    chk("t2_err_beat2", 32'(err_sel), 32'd1);
    send(2'd0, 8'h12, 1'b1, 1, w);
    chk("t2_out_valid_b3", 32'(bus.out_valid), 32'h2);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("t2_err_cleared", 32'(err_sel), 32'd0);

    // 3: backpressure on channel 0
    bus.out_ready = 4'b1110;
    send(2'd0, 8'h21, 1'b0, 0, w);
    chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      send(2'd2, 8'h22, 1'b1, 0, w);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t3_hold_valid", 32'(bus.out_valid), 32'h1);
          chk("t3_hold_data", 32'(bus.out_data), 32'h21);
          chk("t3_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 4'b1111;
      end
    join
    chk("t3_second_beat", 32'(bus.out_data), 32'h22);
    @(posedge clk); #1;

    // 5: counter wrap on channel 3
    for (int i = 0; i < 5; i++) begin
      send(2'd3, 8'h30 + 8'(i), 1'b1, 3, w);
      @(posedge clk); #1;
      chk($sformatf("t5_wrap%0d", i), 32'(pkt_cnt[3*CW +: CW]), 32'(wrap_seq[i]));
    end

    // 4: 16 back-to-back beats, one packet on channel 3
    for (int i = 0; i < 16; i++) begin
      send((i == 0) ? 2'd3 : 2'(i), 8'h40 + 8'(i), (i == 15), 3, w);
      chk("t4_no_wait", 32'(w), 32'd0);
      chk("t4_latency_valid", 32'(bus.out_valid), 32'h8);
      chk("t4_latency_data", 32'(bus.out_data), 32'(8'h40 + 8'(i)));
      chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
    end
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // 6: reset mid-packet with a beat buffered
    bus.out_ready = 4'b0000;
    send(2'd1, 8'h77, 1'b0, 1, w);
    chk("t6_buffered", 32'(bus.out_valid), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    send(2'd2, 8'h88, 1'b1, 2, w);
    chk("t6_route_ch2", 32'(bus.out_valid), 32'h4);
    chk("t6_data", 32'(bus.out_data), 32'h88);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
